// File: rtl/control_bus_rtc_pkg.sv
// Shared definitions for the RTC multiplexed-bus master: state encoding,
// default phase timing and command layout.
package rtc_bus_pkg;

   // state        | meaning
   // ST_IDLE      | bus released, waiting for a micro command
   // ST_A_SETUP   | address driven, a_d=0, before the write strobe
   // ST_A_PULSE   | address latched into the RTC with wr_n low
   // ST_A_HOLD    | address held after the strobe
   // ST_GAP       | cs_n high, bus released between phases
   // ST_D_SETUP   | data phase setup, a_d=1
   // ST_D_PULSE   | wr_n (write) or rd_n (read) low
   // ST_D_HOLD    | data held / read result already captured
   localparam logic [2:0] ST_IDLE    = 3'd0;
   localparam logic [2:0] ST_A_SETUP = 3'd1;
   localparam logic [2:0] ST_A_PULSE = 3'd2;
   localparam logic [2:0] ST_A_HOLD  = 3'd3;
   localparam logic [2:0] ST_GAP     = 3'd4;
   localparam logic [2:0] ST_D_SETUP = 3'd5;
   localparam logic [2:0] ST_D_PULSE = 3'd6;
   localparam logic [2:0] ST_D_HOLD  = 3'd7;

   localparam int DEF_SETUP_CYC = 2;
   localparam int DEF_PULSE_CYC = 4;
   localparam int DEF_HOLD_CYC  = 2;
   localparam int DEF_GAP_CYC   = 4;

   localparam int OP_BIT     = 7;
   localparam int RTC_ADDR_W = 7;
   localparam int TMR_W      = 8;

   typedef enum logic {
      OP_WRITE = 1'b0,
      OP_READ  = 1'b1
   } rtc_op_e;

   typedef struct packed {
      rtc_op_e    op;
      logic [7:0] addr;
      logic [7:0] wdata;
   } rtc_cmd_t;

   // Timer load value for a phase lasting cyc cycles (counter runs cyc-1 .. 0).
   function automatic logic [TMR_W-1:0] cyc_to_load(input int cyc);
      return TMR_W'(cyc - 1);
   endfunction

endpackage

// File: rtl/control_bus_rtc_if.sv
// Micro-side port signals and RTC pins of the bus master, bundled together.
interface control_bus_rtc_if;
   logic [7:0] out_port;
   logic [7:0] dir;
   logic       writestrobe;
   logic       read_strobe;
   logic       actRTC;
   logic [7:0] in_portRTC;
   logic       busy;
   logic       overrun;
   logic [7:0] ad_out;
   logic       ad_oe;
   logic [7:0] ad_in;
   logic       a_d;
   logic       cs_n;
   logic       wr_n;
   logic       rd_n;

   modport master (
      input  out_port, dir, writestrobe, read_strobe, actRTC, ad_in,
      output in_portRTC, busy, overrun, ad_out, ad_oe, a_d, cs_n, wr_n, rd_n
   );

   modport slave (
      output out_port, dir, writestrobe, read_strobe, actRTC, ad_in,
      input  in_portRTC, busy, overrun, ad_out, ad_oe, a_d, cs_n, wr_n, rd_n
   );
endinterface

// File: rtl/control_bus_rtc_timer.sv
// Loadable phase down-counter; done flags the terminal count of the current phase.
module rtc_phase_timer #(
   parameter int W = 8
)(
   input  logic         clk,
   input  logic         reset,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         count,
   output logic         done
);

   logic [W-1:0] cnt;

   // Load on phase entry, otherwise count down and park at zero.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= load_val;
      end else if (count && (cnt != '0)) begin
         cnt <= cnt - 1'b1;
      end
   end

   assign done = count && (cnt == '0);

endmodule

// File: rtl/control_bus_rtc.sv
// Bus master for the RTC multiplexed address/data port: turns each accepted
// micro command into an address phase followed by a data phase.
module control_bus_rtc
   import rtc_bus_pkg::*;
#(
   parameter int SETUP_CYC = DEF_SETUP_CYC,
   parameter int PULSE_CYC = DEF_PULSE_CYC,
   parameter int HOLD_CYC  = DEF_HOLD_CYC,
   parameter int GAP_CYC   = DEF_GAP_CYC
)(
   input logic               clk,
   input logic               reset,
   control_bus_rtc_if.master bus
);

   logic [2:0]       state, state_nxt;
   rtc_cmd_t         cmd_q, cmd_nxt;
   logic             cmd_hit, accept;
   logic             tmr_load, tmr_count, tmr_done;
   logic [TMR_W-1:0] tmr_val;
   logic             busy_q, overrun_q;
   logic [7:0]       rdata_q, ad_out_q;
   logic             ad_oe_q, a_d_q, cs_n_q, wr_n_q, rd_n_q;
   logic             unused_rd_strobe;

   // read_strobe only steers the micro's input mux; it never starts a bus cycle.
   assign unused_rd_strobe = bus.read_strobe;

   assign cmd_hit   = bus.actRTC & bus.writestrobe;
   assign accept    = (state == ST_IDLE) && cmd_hit;
   assign tmr_count = (state != ST_IDLE);

   function automatic logic [TMR_W-1:0] phase_load(input logic [2:0] st);
      case (st)
         ST_A_SETUP, ST_D_SETUP: phase_load = cyc_to_load(SETUP_CYC);
         ST_A_PULSE, ST_D_PULSE: phase_load = cyc_to_load(PULSE_CYC);
         ST_A_HOLD,  ST_D_HOLD:  phase_load = cyc_to_load(HOLD_CYC);
         ST_GAP:                 phase_load = cyc_to_load(GAP_CYC);
         default:                phase_load = '0;
      endcase
   endfunction

   // Fixed phase sequence; every phase change reloads the timer.
   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:    if (cmd_hit)  state_nxt = ST_A_SETUP;
         ST_A_SETUP: if (tmr_done) state_nxt = ST_A_PULSE;
         ST_A_PULSE: if (tmr_done) state_nxt = ST_A_HOLD;
         ST_A_HOLD:  if (tmr_done) state_nxt = ST_GAP;
         ST_GAP:     if (tmr_done) state_nxt = ST_D_SETUP;
         ST_D_SETUP: if (tmr_done) state_nxt = ST_D_PULSE;
         ST_D_PULSE: if (tmr_done) state_nxt = ST_D_HOLD;
         ST_D_HOLD:  if (tmr_done) state_nxt = ST_IDLE;
         default:                  state_nxt = ST_IDLE;
      endcase
      tmr_load = (state_nxt != state);
      tmr_val  = phase_load(state_nxt);
   end

   // Command that the registered outputs must reflect after this edge.
   always_comb begin
      cmd_nxt = cmd_q;
      if (accept) begin
         cmd_nxt.op    = rtc_op_e'(bus.dir[OP_BIT]);
         cmd_nxt.addr  = {1'b0, bus.dir[RTC_ADDR_W-1:0]};
         cmd_nxt.wdata = bus.out_port;
      end
   end

   rtc_phase_timer #(.W(TMR_W)) u_timer (
      .clk      (clk),
      .reset    (reset),
      .load     (tmr_load),
      .load_val (tmr_val),
      .count    (tmr_count),
      .done     (tmr_done)
   );

   // State and latched command.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= ST_IDLE;
         cmd_q <= '0;
      end else begin
         state <= state_nxt;
         cmd_q <= cmd_nxt;
      end
   end

   // Sticky overrun: set by a command during a transaction, cleared by the next accepted one.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         overrun_q <= 1'b0;
      end else if (cmd_hit) begin
         overrun_q <= (state != ST_IDLE);
      end
   end

   // Read result captured on the edge that closes the data strobe.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rdata_q <= '0;
      end else if ((state == ST_D_PULSE) && tmr_done && (cmd_q.op == OP_READ)) begin
         rdata_q <= bus.ad_in;
      end
   end

   // Pin values decoded from the next state so every control leaves a flop.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         busy_q   <= 1'b0;
         ad_out_q <= '0;
         ad_oe_q  <= 1'b0;
         a_d_q    <= 1'b0;
         cs_n_q   <= 1'b1;
         wr_n_q   <= 1'b1;
         rd_n_q   <= 1'b1;
      end else begin
         busy_q   <= (state_nxt != ST_IDLE);
         ad_out_q <= '0;
         ad_oe_q  <= 1'b0;
         a_d_q    <= 1'b0;
         cs_n_q   <= 1'b1;
         wr_n_q   <= 1'b1;
         rd_n_q   <= 1'b1;
         case (state_nxt)
            ST_A_SETUP, ST_A_PULSE, ST_A_HOLD: begin
               cs_n_q   <= 1'b0;
               ad_oe_q  <= 1'b1;
               ad_out_q <= cmd_nxt.addr;
               wr_n_q   <= (state_nxt != ST_A_PULSE);
            end
            ST_D_SETUP, ST_D_PULSE, ST_D_HOLD: begin
               cs_n_q <= 1'b0;
               a_d_q  <= 1'b1;
               if (cmd_nxt.op == OP_WRITE) begin
                  ad_oe_q  <= 1'b1;
                  ad_out_q <= cmd_nxt.wdata;
                  wr_n_q   <= (state_nxt != ST_D_PULSE);
               end else begin
                  rd_n_q <= (state_nxt != ST_D_PULSE);
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.busy       = busy_q;
   assign bus.overrun    = overrun_q;
   assign bus.in_portRTC = rdata_q;
   assign bus.ad_out     = ad_out_q;
   assign bus.ad_oe      = ad_oe_q;
   assign bus.a_d        = a_d_q;
   assign bus.cs_n       = cs_n_q;
   assign bus.wr_n       = wr_n_q;
   assign bus.rd_n       = rd_n_q;

endmodule

// File: doc/control_bus_rtc.md
# control_bus_rtc

Bus master for the external RTC's multiplexed address/data port, sitting directly downstream of `encapsulado_micro`. It consumes the PicoBlaze output port (`out_port`, `dir`, `writestrobe`, `read_strobe`, `actRTC`) and turns each accepted access into a timed two-phase bus transaction (address phase, then data phase) on the RTC pins. Read data is latched and driven back on `in_portRTC` for the micro's input mux.

## Interface
- `SETUP_CYC`, default 2: cycles that `ad`/`a_d` are stable before a strobe pulse.
- `PULSE_CYC`, default 4: width of each `wr_n`/`rd_n` low pulse, in cycles.
- `HOLD_CYC`, default 2: cycles that `ad`/`a_d` are held after a pulse.
- `GAP_CYC`, default 4: idle cycles between the address phase and the data phase, with `cs_n` high.
- `clk`  in  1  system clock (100 MHz).
- `reset`  in  1  asynchronous, active-high reset.
- `out_port`  in  8  write data from the micro.
- `dir`  in  8  port address from the micro. `dir[7]`=0 means write, `dir[7]`=1 means read; `dir[6:0]` is the RTC register.
- `writestrobe`  in  1  one-cycle micro write strobe.
- `read_strobe`  in  1  one-cycle micro read strobe. It has no effect on the bus.
- `actRTC`  in  1  RTC device select from the micro's decoder.
- `in_portRTC`  out  8  last read result (`rdata`).
- `busy`  out  1  a transaction is in progress.
- `overrun`  out  1  sticky flag: a command arrived while busy.
- `ad_out`  out  8  bus value driven toward the RTC.
- `ad_oe`  out  1  output enable for the top-level tristate on `ad`.
- `ad_in`  in  8  bus value sampled from the RTC.
- `a_d`  out  1  0 = address phase, 1 = data phase.
- `cs_n`, `wr_n`, `rd_n`  out  1 each  active-low RTC controls.

## Operation
- **Command accept.** A command is accepted in IDLE on a rising `clk` when `actRTC & writestrobe` is high. The block latches `op` (from `dir[7]`), `addr` (`{1'b0,dir[6:0]}`) and `wdata` (`out_port`).
- **Read sequence.** The micro issues a write to a `dir` with bit 7 set, polls `busy` through the top level, then reads `in_portRTC`.
- **Commands while busy.** If `actRTC & writestrobe` occurs while not IDLE, the command is ignored and `overrun` is set to 1. `overrun` clears on the next accepted command.
- **States.** IDLE → A_SETUP → A_PULSE → A_HOLD → GAP → D_SETUP → D_PULSE → D_HOLD → IDLE. Each state lasts its parameter's number of cycles, counted by the phase timer.
- **A_\* states:**
  - `a_d`=0, `cs_n`=0, `ad_oe`=1, `ad_out`=`addr`.
  - `wr_n`=0 only in A_PULSE.
- **GAP state:** `cs_n`=1, `ad_oe`=0, `wr_n`=`rd_n`=1.
- **D_\* states, write:**
  - `a_d`=1, `cs_n`=0, `ad_oe`=1, `ad_out`=`wdata`.
  - `wr_n`=0 in D_PULSE.
- **D_\* states, read:**
  - `a_d`=1, `cs_n`=0, `ad_oe`=0.
  - `rd_n`=0 in D_PULSE.
  - `rdata` ← `ad_in` at the clock edge that ends the last D_PULSE cycle.
- **IDLE state:** `cs_n`=`wr_n`=`rd_n`=1, `a_d`=0, `ad_oe`=0, `ad_out`=0.
- **Data hold.** `rdata` holds its value until the next read completes. Writes never modify it.
- **Glitch-free controls.** All RTC control outputs are registered.

## Timing
- **Reset values:** `busy`=0, `overrun`=0, `in_portRTC`=0, `ad_out`=0, `ad_oe`=0, `a_d`=0, `cs_n`=`wr_n`=`rd_n`=1, state IDLE. Reset is asynchronous and takes effect immediately.
- **Reset mid-transaction:** the bus is released in the same instant and `rdata` is cleared. No partial pulse may remain low after reset deasserts.
- **Busy window:** command accepted at edge k; `busy`=1 from k+1 for exactly 2·(SETUP+PULSE+HOLD)+GAP cycles (20 at defaults), and `busy`=0 again after that.
- **Next command:** accepted on the first IDLE edge after that, with no dead cycle required.
- **Read data:** valid on `in_portRTC` from the first D_HOLD cycle, before `busy` falls.
- **Simultaneous strobes:** `read_strobe` is ignored in every state. Only `writestrobe` matters.
- **Parameters:** each must be ≥1. The phase counter is wide enough for the maximum parameter (8 bits).

## Structure
- **Shared package `rtc_bus_pkg`:**
  - state encoding (3-bit localparams, 8 states);
  - default timing constants;
  - `OP_BIT`=7 and `RTC_ADDR_W`=7.
- **Sub-module `rtc_phase_timer`:**
  - loadable down-counter with `load`, `count` and a `done` pulse;
  - the FSM loads it on every state entry.
- **Tristate on `ad`:** lives in the top level, not in this block.

## Test plan
- **Write:** `dir`=0x21, `out_port`=0x59, `writestrobe`+`actRTC` → address phase shows `ad_out`=0x21, `a_d`=0, `wr_n` low 4 cycles; data phase shows `ad_out`=0x59, `a_d`=1, `wr_n` low 4 cycles; `busy` high exactly 20 cycles.
- **Read:** `dir`=0xA3, with `ad_in`=0x47 during D_PULSE → `rd_n` low 4 cycles and `ad_oe`=0 in the data phase; `in_portRTC`=0x47 before `busy` falls.
- **Overrun:** a second `writestrobe` 5 cycles into a transaction → the second command is ignored and `overrun`=1. The next accepted command clears `overrun`.
- **Deselected:** `writestrobe` with `actRTC`=0, and `read_strobe` with `actRTC`=1 → no bus activity and `busy` stays 0.
- **Reset mid-transaction:** `reset` during A_PULSE → in the same cycle `cs_n`=`wr_n`=1, `ad_oe`=0, `busy`=0. A new write after release completes normally.
- **Back-to-back:** a write issued on the first IDLE cycle after a read → accepted; `in_portRTC` retains the read value.
